// File: rtl/wm8731_i2c_target.sv
// Write-only I2C responder emulating the WM8731 control port (START, addr, 2 data bytes, STOP).
// Define WM8731_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL/SDA.
`timescale 1ns/1ps

// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in address + R/W byte
// ACK_A     | holding SDA low for the address ACK
// BYTE1     | shifting in byte1 (reg addr + data bit 8)
// ACK1      | holding SDA low for the byte1 ACK
// BYTE2     | shifting in byte2 (data bits 7:0)
// ACK2      | holding SDA low for the byte2 ACK, write issued on release
// WAIT_STOP | frame complete, extra bytes NACKed
// IGNORE    | not addressed, passive until START or STOP
module wm8731_i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       i2c_sclk,
    inout  wire        i2c_data,
    output logic       wr_valid,
    output logic [6:0] wr_reg_addr,
    output logic [8:0] wr_reg_data,
    output logic       busy,
    output logic       frame_err
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] ADDR      = 4'd1;
    localparam logic [3:0] ACK_A     = 4'd2;
    localparam logic [3:0] BYTE1     = 4'd3;
    localparam logic [3:0] ACK1      = 4'd4;
    localparam logic [3:0] BYTE2     = 4'd5;
    localparam logic [3:0] ACK2      = 4'd6;
    localparam logic [3:0] WAIT_STOP = 4'd7;
    localparam logic [3:0] IGNORE    = 4'd8;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_line;
    logic                   sda_line;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   sda_rise;
    logic                   sda_fall;
    logic                   start_det;
    logic                   stop_det;
    logic                   in_frame;

    logic [3:0]             state;
    logic [7:0]             shreg;
    logic [7:0]             byte1;
    logic [7:0]             byte2;
    logic [2:0]             bit_cnt;
    logic                   got_bit;
    logic                   sda_oe;

    // Open-drain: only ever pull low or release.
    assign i2c_data = sda_oe ? 1'b0 : 1'bz;

    // Idle bus level is high, so synchronizers reset to 1 to avoid phantom edges.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_sclk};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_data};
        end
    end

`ifdef WM8731_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;
    logic       scl_filt;
    logic       sda_filt;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[SYNC_STAGES-1]};
            sda_hist <= {sda_hist[0], sda_sync[SYNC_STAGES-1]};
            scl_filt <= maj3(scl_sync[SYNC_STAGES-1], scl_hist[0], scl_hist[1]);
            sda_filt <= maj3(sda_sync[SYNC_STAGES-1], sda_hist[0], sda_hist[1]);
        end
    end

    assign scl_line = scl_filt;
    assign sda_line = sda_filt;
`else
    assign scl_line = scl_sync[SYNC_STAGES-1];
    assign sda_line = sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_line;
            sda_d <= sda_line;
        end
    end

    assign scl_rise  = scl_line & ~scl_d;
    assign scl_fall  = ~scl_line & scl_d;
    assign sda_rise  = sda_line & ~sda_d;
    assign sda_fall  = ~sda_line & sda_d;
    // Qualifying by SCL high keeps our own ACK edges (made while SCL is low) out.
    assign start_det = sda_fall & scl_line;
    assign stop_det  = sda_rise & scl_line;
    assign in_frame  = (state == ACK_A) || (state == BYTE1) ||
                       (state == ACK1)  || (state == BYTE2);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shreg       <= '0;
            byte1       <= '0;
            byte2       <= '0;
            bit_cnt     <= '0;
            got_bit     <= 1'b0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            wr_valid    <= 1'b0;
            wr_reg_addr <= '0;
            wr_reg_data <= '0;
            frame_err   <= 1'b0;
        end else begin
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (stop_det) begin
                frame_err <= in_frame;
                state     <= IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                bit_cnt   <= '0;
                got_bit   <= 1'b0;
            end else if (start_det) begin
                frame_err <= in_frame;
                state     <= ADDR;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                bit_cnt   <= '0;
                got_bit   <= 1'b0;
            end else begin
                if (scl_rise) begin
                    shreg   <= {shreg[6:0], sda_line};
                    got_bit <= 1'b1;
                end
                if (scl_fall) begin
                    got_bit <= 1'b0;
                    case (state)
                        ADDR, BYTE1, BYTE2: begin
                            // The fall right after START has no bit behind it and is not counted.
                            if (got_bit) begin
                                if (bit_cnt == 3'd7) begin
                                    bit_cnt <= '0;
                                    if (state == ADDR) begin
                                        if (shreg[7:1] == DEV_ADDR && !shreg[0]) begin
                                            sda_oe <= 1'b1;
                                            busy   <= 1'b1;
                                            state  <= ACK_A;
                                        end else begin
                                            state  <= IGNORE;
                                        end
                                    end else if (state == BYTE1) begin
                                        byte1  <= shreg;
                                        sda_oe <= 1'b1;
                                        state  <= ACK1;
                                    end else begin
                                        byte2  <= shreg;
                                        sda_oe <= 1'b1;
                                        state  <= ACK2;
                                    end
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                end
                            end
                        end
                        ACK_A: begin
                            sda_oe <= 1'b0;
                            state  <= BYTE1;
                        end
                        ACK1: begin
                            sda_oe <= 1'b0;
                            state  <= BYTE2;
                        end
                        ACK2: begin
                            sda_oe      <= 1'b0;
                            wr_reg_addr <= byte1[7:1];
                            wr_reg_data <= {byte1[0], byte2};
                            wr_valid    <= 1'b1;
                            state       <= WAIT_STOP;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
